// File: rtl/morra_move_collector.sv
// Morra move collector: latches one private move per player, issues the pair for one cycle,
// then holds off. Optional MORRA_FORFEIT_EN issues a forfeit round on commit timeout.
module morra_move_collector #(
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned HOLDOFF_CYCLES = 4,
   parameter int unsigned CNT_W          = 16
) (
   input  logic       clk,
   input  logic       RST,
   input  logic       START_REQ,
   input  logic [1:0] P1_IN,
   input  logic       P1_VLD,
   input  logic [1:0] P2_IN,
   input  logic       P2_VLD,
   output logic [1:0] P1,
   output logic [1:0] P2,
   output logic       START,
   output logic       P1_LOCKED,
   output logic       P2_LOCKED,
   output logic       TIMEOUT,
   output logic       BUSY
);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_ISSUE, S_HOLDOFF} state_t;

   localparam int unsigned TO_L = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam int unsigned HO_L = (HOLDOFF_CYCLES == 0) ? 0 : HOLDOFF_CYCLES - 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_L);
   localparam logic [CNT_W-1:0] HO_LAST = CNT_W'(HO_L);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

   state_t           state, state_nxt;
   logic [1:0]       m1_q, m2_q;
   logic             l1_q, l2_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       p1_q, p2_q, p1_nxt, p2_nxt;
   logic             start_q, to_q, to_nxt;
   logic             take1, take2, one_locked, both_locked, expire, issue_go, cnt_max;
   logic [1:0]       issue_m1, issue_m2;

`ifdef MORRA_FORFEIT_EN
   // The absent player is credited with the move that loses to the committed one.
   function automatic logic [1:0] loser_of(input logic [1:0] m);
      case (m)
         2'b01:   loser_of = 2'b11;
         2'b10:   loser_of = 2'b01;
         2'b11:   loser_of = 2'b10;
         default: loser_of = 2'b00;
      endcase
   endfunction
`endif

   assign take1       = (state == S_COLLECT) && P1_VLD && (P1_IN != 2'b00) && !l1_q;
   assign take2       = (state == S_COLLECT) && P2_VLD && (P2_IN != 2'b00) && !l2_q;
   assign one_locked  = l1_q ^ l2_q;
   assign both_locked = l1_q & l2_q;
   assign cnt_max     = &cnt_q;
   // A second commit landing on the expiry edge wins over the timeout.
   assign expire      = TO_EN && (state == S_COLLECT) && one_locked && (cnt_q >= TO_LAST)
                        && !(take1 || take2);

   // state register
   always_ff @(posedge clk) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    state_nxt = S_IDLE;
         S_COLLECT: begin
            if (both_locked) state_nxt = S_ISSUE;
`ifdef MORRA_FORFEIT_EN
            else if (expire) state_nxt = S_ISSUE;
`endif
         end
         S_ISSUE:   state_nxt = (HOLDOFF_CYCLES == 0) ? S_COLLECT : S_HOLDOFF;
         S_HOLDOFF: if (cnt_q >= HO_LAST) state_nxt = S_COLLECT;
         default:   state_nxt = S_IDLE;
      endcase
      if (START_REQ) state_nxt = S_COLLECT;
   end

   // output logic (next values for the registered outputs, plus BUSY)
   always_comb begin
      issue_go = (state == S_COLLECT) && (state_nxt == S_ISSUE);
`ifdef MORRA_FORFEIT_EN
      issue_m1 = l1_q ? m1_q : loser_of(m2_q);
      issue_m2 = l2_q ? m2_q : loser_of(m1_q);
`else
      issue_m1 = m1_q;
      issue_m2 = m2_q;
`endif
      p1_nxt = issue_go ? issue_m1 : 2'b00;
      p2_nxt = issue_go ? issue_m2 : 2'b00;
      to_nxt = expire && !START_REQ;
      BUSY   = (state == S_ISSUE) || (state == S_HOLDOFF);
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         p1_q <= 2'b00; p2_q <= 2'b00; start_q <= 1'b0; to_q <= 1'b0;
         m1_q <= 2'b00; m2_q <= 2'b00; l1_q <= 1'b0; l2_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         p1_q    <= p1_nxt;
         p2_q    <= p2_nxt;
         start_q <= START_REQ;
         to_q    <= to_nxt;

         // Moves are copied to P1/P2 on the issue edge, so the latches can drop then.
         if (START_REQ || issue_go || expire) begin
            m1_q <= 2'b00; m2_q <= 2'b00; l1_q <= 1'b0; l2_q <= 1'b0;
         end else begin
            if (take1) begin m1_q <= P1_IN; l1_q <= 1'b1; end
            if (take2) begin m2_q <= P2_IN; l2_q <= 1'b1; end
         end

         if (START_REQ || issue_go || expire) cnt_q <= '0;
         else if (state == S_COLLECT) begin
            if (!one_locked)  cnt_q <= '0;
            else if (!cnt_max) cnt_q <= cnt_q + CNT_ONE;
         end else if (state == S_HOLDOFF) begin
            if (state_nxt == S_COLLECT) cnt_q <= '0;
            else if (!cnt_max)          cnt_q <= cnt_q + CNT_ONE;
         end else cnt_q <= '0;
      end
   end

   assign P1        = p1_q;
   assign P2        = p2_q;
   assign START     = start_q;
   assign TIMEOUT   = to_q;
   assign P1_LOCKED = l1_q;
   assign P2_LOCKED = l2_q;

endmodule

// File: tb/tb_morra_move_collector.sv
// Directed bench for morra_move_collector (TIMEOUT_CYCLES=8, HOLDOFF_CYCLES=4).
// Forfeit expectations switch with MORRA_FORFEIT_EN.
module tb_morra_move_collector;

   logic       clk = 1'b0;
   logic       RST, START_REQ, P1_VLD, P2_VLD;
   logic [1:0] P1_IN, P2_IN, P1, P2;
   logic       START, P1_LOCKED, P2_LOCKED, TIMEOUT, BUSY;
   int         passes = 0, total = 0;

   morra_move_collector #(.TIMEOUT_CYCLES(8), .HOLDOFF_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .RST(RST), .START_REQ(START_REQ),
      .P1_IN(P1_IN), .P1_VLD(P1_VLD), .P2_IN(P2_IN), .P2_VLD(P2_VLD),
      .P1(P1), .P2(P2), .START(START), .P1_LOCKED(P1_LOCKED), .P2_LOCKED(P2_LOCKED),
      .TIMEOUT(TIMEOUT), .BUSY(BUSY)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // exp fields: {P1, P2, START, P1_LOCKED, P2_LOCKED, TIMEOUT, BUSY}
   task automatic chk(input string tag, input logic [8:0] exp);
      logic [8:0] obs;
      obs = {P1, P2, START, P1_LOCKED, P2_LOCKED, TIMEOUT, BUSY};
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%b required=%b", tag, obs, exp);
   endtask

   initial begin
      RST = 1'b1; START_REQ = 1'b0; P1_VLD = 1'b0; P2_VLD = 1'b0; P1_IN = 2'b00; P2_IN = 2'b00;
      tick(); tick();
      chk("reset", 9'b00_00_0_0_0_0_0);

      // start pulse
      RST = 1'b0; START_REQ = 1'b1; tick();
      chk("start_pulse", 9'b00_00_1_0_0_0_0);
      START_REQ = 1'b0; tick();
      chk("start_drop", 9'b00_00_0_0_0_0_0);

      // invalid move code ignored
      P1_VLD = 1'b1; P1_IN = 2'b00; tick();
      chk("vld_00_ignored", 9'b00_00_0_0_0_0_0);

      // normal round: P1=01, P2=11 three cycles later
      P1_IN = 2'b01; tick();
      chk("p1_lock", 9'b00_00_0_1_0_0_0);
      P1_VLD = 1'b0; tick(); tick();
      P2_VLD = 1'b1; P2_IN = 2'b11; tick();
      chk("both_locked", 9'b00_00_0_1_1_0_0);
      P2_VLD = 1'b0; tick();
      chk("issue_01_11", 9'b01_11_0_0_0_0_1);
      P1_VLD = 1'b1; P1_IN = 2'b10; tick();
      chk("holdoff_1", 9'b00_00_0_0_0_0_1);
      tick(); tick(); tick();
      chk("holdoff_4", 9'b00_00_0_0_0_0_1);
      tick();
      chk("holdoff_done", 9'b00_00_0_0_0_0_0);
      P1_VLD = 1'b0; tick();
      chk("holdoff_vld_not_queued", 9'b00_00_0_0_0_0_0);

      // simultaneous commit, then a locked player's re-commit is ignored
      P1_VLD = 1'b1; P1_IN = 2'b10; P2_VLD = 1'b1; P2_IN = 2'b10; tick();
      chk("simul_lock", 9'b00_00_0_1_1_0_0);
      P2_VLD = 1'b0; P1_IN = 2'b01; tick();
      chk("issue_10_10", 9'b10_10_0_0_0_0_1);
      P1_VLD = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("back_to_collect", 9'b00_00_0_0_0_0_0);

      // single commit left to expire
`ifdef MORRA_FORFEIT_EN
      P2_VLD = 1'b1; P2_IN = 2'b10; tick();
      chk("p2_lock_alone", 9'b00_00_0_0_1_0_0);
      P2_VLD = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("pre_timeout", 9'b00_00_0_0_1_0_0);
      tick();
      chk("forfeit_issue", 9'b01_10_0_0_0_1_1);
      tick();
      chk("forfeit_after", 9'b00_00_0_0_0_0_1);
`else
      P1_VLD = 1'b1; P1_IN = 2'b11; tick();
      chk("p1_lock_alone", 9'b00_00_0_1_0_0_0);
      P1_VLD = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("pre_timeout", 9'b00_00_0_1_0_0_0);
      tick();
      chk("timeout_pulse", 9'b00_00_0_0_0_1_0);
      tick();
      chk("timeout_after", 9'b00_00_0_0_0_0_0);
`endif
      for (int i = 0; i < 4; i++) tick();

      // full round after timeout, P2 first
      P2_VLD = 1'b1; P2_IN = 2'b01; tick();
      chk("post_to_p2_lock", 9'b00_00_0_0_1_0_0);
      P2_VLD = 1'b0; P1_VLD = 1'b1; P1_IN = 2'b11; tick();
      P1_VLD = 1'b0; tick();
      chk("issue_11_01", 9'b11_01_0_0_0_0_1);
      for (int i = 0; i < 5; i++) tick();

      // START_REQ beats a completing commit
      P1_VLD = 1'b1; P1_IN = 2'b01; tick();
      P1_VLD = 1'b0; P2_VLD = 1'b1; P2_IN = 2'b10; START_REQ = 1'b1; tick();
      chk("start_beats_commit", 9'b00_00_1_0_0_0_0);
      P2_VLD = 1'b0; START_REQ = 1'b0; tick();
      chk("no_issue_after_start", 9'b00_00_0_0_0_0_0);

      // reset during hold-off
      P1_VLD = 1'b1; P2_VLD = 1'b1; P1_IN = 2'b01; P2_IN = 2'b01; tick();
      P1_VLD = 1'b0; P2_VLD = 1'b0; tick();
      chk("issue_01_01", 9'b01_01_0_0_0_0_1);
      tick(); tick();
      chk("mid_holdoff", 9'b00_00_0_0_0_0_1);
      RST = 1'b1; tick();
      chk("rst_mid_holdoff", 9'b00_00_0_0_0_0_0);
      RST = 1'b0; P1_VLD = 1'b1; P1_IN = 2'b01; tick();
      chk("idle_ignores_vld", 9'b00_00_0_0_0_0_0);
      P1_VLD = 1'b0; tick();

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/morra_move_collector.md
Name: morra_move_collector

Overview:
- Input stage directly upstream of the Morra Cinese game core.
- Collects one move per player through independent valid strobes and holds each move privately until both players have committed.
- Presents the move pair on P1/P2 for exactly one cycle, outside which P1/P2 = 00, the core's "no move" code.
- Generates the core's START pulse and enforces a commit timeout and a post-round hold-off.

Parameters:
- TIMEOUT_CYCLES, 1000: max cycles after the first commit to wait for the second commit; 0 disables the timeout.
- HOLDOFF_CYCLES, 4: cycles after an issue during which inputs are ignored, so the core settles ROUND/GAME.
- CNT_W, 16: width of the shared timeout/hold-off counter; must satisfy TIMEOUT_CYCLES and HOLDOFF_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge
- RST  in  1  synchronous active-high reset
- START_REQ  in  1  request a new game; level or pulse, edge-insensitive
- P1_IN  in  2  player 1 move: 01 / 10 / 11; 00 is not a move
- P1_VLD  in  1  player 1 commit strobe
- P2_IN  in  2  player 2 move
- P2_VLD  in  1  player 2 commit strobe
- P1  out  2  move to core; 00 except during ISSUE
- P2  out  2  move to core; 00 except during ISSUE
- START  out  1  one-cycle game-start pulse to core
- P1_LOCKED  out  1  player 1 move held; the move value itself is never exposed
- P2_LOCKED  out  1  player 2 move held
- TIMEOUT  out  1  one-cycle pulse when the commit window expires
- BUSY  out  1  high in ISSUE and HOLDOFF

Behaviour:
- Reset: all outputs 0; latches and counter cleared; state = IDLE. RST overrides everything, including mid-HOLDOFF or during ISSUE.
- States: IDLE, COLLECT, ISSUE, HOLDOFF.
- IDLE:
  - P1/P2 = 00; VLD inputs ignored.
  - START_REQ=1 → START=1 on the next cycle, then state = COLLECT.
- START_REQ priority: in any state, START_REQ=1 clears both latches, the counter and pending TIMEOUT, pulses START for one cycle and enters COLLECT. It wins over simultaneous VLD, timeout or issue events. START_REQ held high re-pulses START every cycle; this is legal.
- COLLECT, locking:
  - Px_VLD=1 with Px_IN≠00 and Px not locked → latch the move, Px_LOCKED=1 from the next cycle.
  - VLD with IN=00 is ignored.
  - VLD while already locked is ignored; the first commit is final.
  - Both players committing in the same cycle → both lock in that edge.
- COLLECT, transition to ISSUE: when both are locked (registered flags), the next cycle is ISSUE. Latency from the second VLD edge to P1/P2 valid is 2 cycles.
- COLLECT, timeout counter:
  - Starts at 0 on the edge where the first player locks and increments each cycle while exactly one player is locked.
  - Reaching TIMEOUT_CYCLES → TIMEOUT=1 for one cycle, both latches cleared, remain in COLLECT.
  - If the second commit arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the commit wins and there is no TIMEOUT.
- ISSUE:
  - Exactly one cycle: P1/P2 = latched moves.
  - Latches cleared, Px_LOCKED=0, counter=0, then state = HOLDOFF.
- HOLDOFF:
  - P1/P2 = 00; VLD inputs ignored (not queued).
  - Counter counts to HOLDOFF_CYCLES, then state = COLLECT.
  - HOLDOFF_CYCLES=0 → goes straight to COLLECT after ISSUE.
- Counter saturates; no wrap-around is permitted.
- P1, P2, START and TIMEOUT are registered outputs, with no combinational path from inputs.

Optional Feature:
- Macro: MORRA_FORFEIT_EN.
- Defined: on timeout with exactly one player locked, skip the discard and enter ISSUE.
  - The locked player's move is output normally.
  - The absent player's output is the move that loses to it: 01→11, 10→01, 11→10.
  - TIMEOUT still pulses, in the same cycle as ISSUE.
- Undefined: timeout discards both latches, as above.

Test Plan:
- Reset / start: RST=1 for 2 cycles, then START_REQ pulse → START=1 for exactly 1 cycle. P1=P2=00 throughout; state = COLLECT.
- Normal round: P1_VLD with P1_IN=01, 3 cycles later P2_VLD with P2_IN=11 → P1=01, P2=11 for one cycle, 2 cycles after P2_VLD. Then BUSY=1 for 1+HOLDOFF_CYCLES cycles, and a VLD during HOLDOFF has no effect.
- Simultaneous and invalid commits: P1_VLD with 00 ignored (P1_LOCKED stays 0). Both VLD in the same cycle with 10/10 → issue 10/10. A re-commit by a locked player with a different move does not change the issued move.
- Timeout with TIMEOUT_CYCLES=8, feature off: only P1 commits 11 → TIMEOUT pulse 8 cycles later, P1_LOCKED→0, no issue. A subsequent full round works.
- Forfeit with MORRA_FORFEIT_EN defined: P2 commits 10 only → at timeout P1=01, P2=10 for one cycle, with TIMEOUT=1.
- Priority: START_REQ asserted in the same cycle as the second commit → START pulse, no ISSUE, both latches cleared. RST mid-HOLDOFF → all outputs 0 next cycle, state = IDLE.
